mem_stage_sized: RTL and testbench

//  Parametrised pipeline MEM stage with an internal word-organised data memory, byte/half/word

---
 rtl/mem_stage_sized.sv | 204 ++++++++++++++++++++
 tb/tb_mem_stage_sized.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sized.sv
// mem_stage_sized
//   Pipeline MEM stage with a private word-organised data memory. Handles
//   byte/half/word stores and loads (little-endian lanes), sign/zero extension
//   of sub-word loads and a fixed multi-cycle read latency. Misaligned requests
//   are not performed; they raise a one-cycle MISALIGN_ERR instead.
//
// Parameters
//   WORD_LEN      data/address width (this generation is 32-bit only)
//   MEM_DEPTH     memory depth in 32-bit words, power of two, >= 4
//   READ_LATENCY  clocks from load accept to MEM_VALID, 1..8
//
// Ports
//   CLK             rising-edge clock
//   RESET           asynchronous reset, active low
//   MEM_READ_EN     load request, sampled only while idle
//   MEM_WRITE_EN    store request, sampled only while idle (wins over a read)
//   MEM_SIZE        00 byte, 01 half, 10 word, 11 treated as word
//   MEM_UNSIGNED    1 = zero-extend, 0 = sign-extend sub-word loads
//   ALU_RESULT      byte address
//   SW_OPERAND      store data (low byte/half used for sub-word stores)
//   DATA_MEMORY_OUT extended load data, registered, changes only with MEM_VALID
//   MEM_VALID       one-cycle pulse when DATA_MEMORY_OUT has been updated
//   MEM_STALL       hold EX/MEM inputs stable while a load is in flight
//   MISALIGN_ERR    one-cycle pulse: previous request misaligned, not performed
module mem_stage_sized #(
  parameter int WORD_LEN     = 32,
  parameter int MEM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                MEM_READ_EN,
  input  logic                MEM_WRITE_EN,
  input  logic [1:0]          MEM_SIZE,
  input  logic                MEM_UNSIGNED,
  input  logic [WORD_LEN-1:0] ALU_RESULT,
  input  logic [WORD_LEN-1:0] SW_OPERAND,
  output logic [WORD_LEN-1:0] DATA_MEMORY_OUT,
  output logic                MEM_VALID,
  output logic                MEM_STALL,
  output logic                MISALIGN_ERR
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(READ_LATENCY + 1);
  // With a single-cycle latency the load completes at its own accept edge,
  // so the BUSY state is never entered.
  localparam bit SINGLE = (READ_LATENCY == 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the sub-word operand onto every lane; the lane mask picks the
  // lane(s) that actually get written.
  function automatic logic [WORD_LEN-1:0] store_data(input logic [1:0] size,
                                                     input logic [WORD_LEN-1:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [WORD_LEN-1:0] load_extend(input logic [WORD_LEN-1:0] word,
                                                      input logic [1:0]          size,
                                                      input logic [1:0]          off,
                                                      input logic                uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return {{24{b[7] & ~uns}}, b};
      2'b01:   return {{16{h[15] & ~uns}}, h};
      default: return word;
    endcase
  endfunction

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [WORD_LEN-1:0]   mem [MEM_DEPTH];

  logic [AW-1:0]         idx_p0;
  logic [1:0]            off_p0;
  logic                  mis_p0;
  logic                  req_p0;
  logic                  store_p0;
  logic                  load_p0;
  logic [3:0]            be_p0;
  logic [WORD_LEN-1:0]   wdata_p0;

  logic [AW-1:0]         idx_p1;
  logic [1:0]            off_p1;
  logic [1:0]            size_p1;
  logic                  uns_p1;

  logic                  fin;
  logic [AW-1:0]         fin_idx;
  logic [1:0]            fin_off;
  logic [1:0]            fin_size;
  logic                  fin_uns;
  logic [WORD_LEN-1:0]   rd_word;

  // Address bits above the memory window wrap silently.
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^ALU_RESULT[WORD_LEN-1:AW+2];

  // p0: request decode in the accept cycle
  assign idx_p0   = ALU_RESULT[AW+1:2];
  assign off_p0   = ALU_RESULT[1:0];
  assign mis_p0   = is_misaligned(MEM_SIZE, off_p0);
  assign req_p0   = RESET && (state == IDLE) && (MEM_READ_EN || MEM_WRITE_EN);
  assign store_p0 = req_p0 && MEM_WRITE_EN && !mis_p0;
  assign load_p0  = req_p0 && !MEM_WRITE_EN && !mis_p0;
  assign be_p0    = lane_mask(MEM_SIZE, off_p0);
  assign wdata_p0 = store_data(MEM_SIZE, SW_OPERAND);

  // Stall covers the accept cycle plus every BUSY cycle; the cycle that shows
  // MEM_VALID is already idle and may accept the next request.
  assign MEM_STALL = load_p0 || ((state == BUSY) && (cnt != '0));

  always_comb begin
    if (SINGLE) begin
      fin      = load_p0;
      fin_idx  = idx_p0;
      fin_off  = off_p0;
      fin_size = MEM_SIZE;
      fin_uns  = MEM_UNSIGNED;
    end else begin
      fin      = (state == BUSY) && (cnt == CNT_LAST);
      fin_idx  = idx_p1;
      fin_off  = off_p1;
      fin_size = size_p1;
      fin_uns  = uns_p1;
    end
  end

  assign rd_word = mem[fin_idx];

  // p1: captured load attributes, held for the whole BUSY period
  always_ff @(posedge CLK) begin
    if (load_p0) begin
      idx_p1  <= idx_p0;
      off_p1  <= off_p0;
      size_p1 <= MEM_SIZE;
      uns_p1  <= MEM_UNSIGNED;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge CLK) begin
    if (store_p0) begin
      for (int k = 0; k < 4; k++) begin
        if (be_p0[k]) mem[idx_p0][8*k +: 8] <= wdata_p0[8*k +: 8];
      end
    end
  end

  // p2: load completion, result register and status pulses
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state           <= IDLE;
      cnt             <= '0;
      DATA_MEMORY_OUT <= '0;
      MEM_VALID       <= 1'b0;
      MISALIGN_ERR    <= 1'b0;
    end else begin
      MEM_VALID    <= fin;
      MISALIGN_ERR <= req_p0 && mis_p0;
      if (fin) DATA_MEMORY_OUT <= load_extend(rd_word, fin_size, fin_off, fin_uns);
      case (state)
        IDLE: begin
          if (load_p0 && !SINGLE) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sized.sv
`timescale 1ns/1ps
module tb_mem_stage_sized;

  localparam int ND = 3;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        rd    [ND];
  logic        wr    [ND];
  logic        uns   [ND];
  logic [1:0]  sz    [ND];
  logic [31:0] addr  [ND];
  logic [31:0] wd    [ND];
  logic [31:0] dout  [ND];
  logic        vld   [ND];
  logic        stall [ND];
  logic        err   [ND];

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] last_data [ND];
  logic [7:0]  mdl [4096];
  vec_t        tbl [19];

  // Instance 0: READ_LATENCY 2, instance 1: 3, instance 2: 1
  for (genvar g = 0; g < ND; g++) begin : g_dut
    mem_stage_sized #(
      .WORD_LEN(32), .MEM_DEPTH(1024),
      .READ_LATENCY((g == 0) ? 2 : (g == 1) ? 3 : 1)
    ) u_dut (
      .CLK(CLK), .RESET(RESET),
      .MEM_READ_EN(rd[g]), .MEM_WRITE_EN(wr[g]), .MEM_SIZE(sz[g]),
      .MEM_UNSIGNED(uns[g]), .ALU_RESULT(addr[g]), .SW_OPERAND(wd[g]),
      .DATA_MEMORY_OUT(dout[g]), .MEM_VALID(vld[g]), .MEM_STALL(stall[g]),
      .MISALIGN_ERR(err[g])
    );
  end

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 3 : 1;
  endfunction

  function automatic vec_t mk(input logic r, input logic w, input logic [1:0] s, input logic u,
                              input logic [31:0] a, input logic [31:0] wdv,
                              input logic [31:0] e, input logic er);
    vec_t v;
    v.rd = r; v.wr = w; v.sz = s; v.uns = u; v.addr = a; v.wdata = wdv; v.exp = e; v.err = er;
    return v;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  // Byte-addressed reference: little-endian assembly and arithmetic extension.
  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    int     b;
    int     n;
    longint v;
    b = int'(a % 4096);
    n = nbytes(s);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(mdl[b + i]) << (8 * i);
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic mdl_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] data);
    int b;
    b = int'(a % 4096);
    for (int i = 0; i < nbytes(s); i++) mdl[b + i] = 8'((data >> (8 * i)) & 32'hFF);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input int d, input logic r, input logic w, input logic [1:0] s,
                       input logic u, input logic [31:0] a, input logic [31:0] wdv);
    rd[d] = r; wr[d] = w; sz[d] = s; uns[d] = u; addr[d] = a; wd[d] = wdv;
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic scramble(input int d);
    drive(d, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
  endtask

  // Tasks start and end just after a rising edge with inputs free to drive.
  task automatic do_load(input int d, input vec_t v, input string nm);
    int L;
    int stalls;
    int lat;
    bit got;
    L = lat_of(d); stalls = 0; lat = 0; got = 0;
    drive(d, v.rd, v.wr, v.sz, v.uns, v.addr, v.wdata);
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge CLK);
      if (vld[d]) begin
        got = 1;
        lat = c;
        chk($sformatf("%s data", nm), dout[d], v.exp);
        chk($sformatf("%s stall in valid cycle", nm), {31'b0, stall[d]}, 32'd0);
      end else if (stall[d]) begin
        stalls++;
      end
      @(posedge CLK); #1;
      if (c + 1 < L) scramble(d);
      else idle(d);
    end
    chk($sformatf("%s valid seen", nm), {31'b0, got}, 32'd1);
    chk($sformatf("%s latency", nm), 32'(lat), 32'(L));
    chk($sformatf("%s stall cycles", nm), 32'(stalls), 32'(L));
    @(negedge CLK);
    chk($sformatf("%s valid pulse width", nm), {31'b0, vld[d]}, 32'd0);
    @(posedge CLK); #1;
    last_data[d] = v.exp;
  endtask

  task automatic apply_op(input int d, input vec_t v, input string nm);
    if (v.err) begin
      drive(d, v.rd, v.wr, v.sz, v.uns, v.addr, v.wdata);
      @(negedge CLK);
      chk($sformatf("%s misalign no stall", nm), {31'b0, stall[d]}, 32'd0);
      @(posedge CLK); #1;
      idle(d);
      @(negedge CLK);
      chk($sformatf("%s misalign err", nm), {31'b0, err[d]}, 32'd1);
      chk($sformatf("%s misalign data held", nm), dout[d], last_data[d]);
      chk($sformatf("%s misalign no valid", nm), {31'b0, vld[d]}, 32'd0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk($sformatf("%s misalign err pulse width", nm), {31'b0, err[d]}, 32'd0);
      @(posedge CLK); #1;
    end else if (v.wr) begin
      drive(d, v.rd, v.wr, v.sz, v.uns, v.addr, v.wdata);
      @(negedge CLK);
      chk($sformatf("%s store no stall", nm), {31'b0, stall[d]}, 32'd0);
      @(posedge CLK); #1;
      idle(d);
      @(negedge CLK);
      chk($sformatf("%s store no err", nm), {31'b0, err[d]}, 32'd0);
      chk($sformatf("%s store no valid", nm), {31'b0, vld[d]}, 32'd0);
      @(posedge CLK); #1;
    end else if (v.rd) begin
      do_load(d, v, nm);
    end else begin
      idle(d);
      @(negedge CLK);
      chk($sformatf("%s nop no stall", nm), {31'b0, stall[d]}, 32'd0);
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    vec_t        v;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] exp_d;
    int          op;
    int          n;

    tbl[0]  = mk(0, 1, 2'd2, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0);
    tbl[1]  = mk(1, 0, 2'd2, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0);
    tbl[2]  = mk(0, 1, 2'd2, 0, 32'h20,   32'h11223344, 32'h0,        0);
    tbl[3]  = mk(0, 1, 2'd0, 0, 32'h21,   32'hAAAAAA80, 32'h0,        0);
    tbl[4]  = mk(1, 0, 2'd2, 0, 32'h20,   32'h0,        32'h11228044, 0);
    tbl[5]  = mk(1, 0, 2'd0, 0, 32'h21,   32'h0,        32'hFFFFFF80, 0);
    tbl[6]  = mk(1, 0, 2'd0, 1, 32'h21,   32'h0,        32'h00000080, 0);
    tbl[7]  = mk(1, 0, 2'd1, 0, 32'h13,   32'h0,        32'h0,        1);
    tbl[8]  = mk(0, 1, 2'd2, 0, 32'h22,   32'h55,       32'h0,        1);
    tbl[9]  = mk(1, 0, 2'd2, 0, 32'h20,   32'h0,        32'h11228044, 0);
    tbl[10] = mk(0, 1, 2'd1, 0, 32'h36,   32'h1234ABCD, 32'h0,        0);
    tbl[11] = mk(1, 0, 2'd1, 0, 32'h36,   32'h0,        32'hFFFFABCD, 0);
    tbl[12] = mk(1, 0, 2'd1, 1, 32'h36,   32'h0,        32'h0000ABCD, 0);
    tbl[13] = mk(0, 1, 2'd2, 0, 32'h1000, 32'hCAFEF00D, 32'h0,        0);
    tbl[14] = mk(1, 0, 2'd2, 0, 32'h0,    32'h0,        32'hCAFEF00D, 0);
    tbl[15] = mk(1, 1, 2'd2, 0, 32'h40,   32'h00000077, 32'h0,        0);
    tbl[16] = mk(1, 0, 2'd3, 1, 32'h40,   32'h0,        32'h00000077, 0);
    tbl[17] = mk(1, 0, 2'd0, 0, 32'h37,   32'h0,        32'hFFFFFFAB, 0);
    tbl[18] = mk(1, 0, 2'd2, 0, 32'h41,   32'h0,        32'h0,        1);

    // Reset state; a load request during reset must not stall
    RESET = 1'b0;
    for (int d = 0; d < ND; d++) begin idle(d); last_data[d] = '0; end
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset d%0d data", d),  dout[d], 32'h0);
      chk($sformatf("reset d%0d valid", d), {31'b0, vld[d]}, 32'd0);
      chk($sformatf("reset d%0d stall", d), {31'b0, stall[d]}, 32'd0);
      chk($sformatf("reset d%0d err", d),   {31'b0, err[d]}, 32'd0);
    end
    idle(0);
    RESET = 1'b1;
    @(posedge CLK); #1;

    // Directed table on the latency-2 instance
    for (int i = 0; i < 19; i++) apply_op(0, tbl[i], $sformatf("tbl%0d", i));

    // Same stores/loads on the latency-1 instance
    for (int i = 0; i < 7; i++) apply_op(2, tbl[i], $sformatf("l1_tbl%0d", i));

    // Back-to-back loads on the latency-3 instance, inputs scrambled while busy
    w0 = 32'hA5A50001;
    w1 = 32'h5A5A0002;
    apply_op(1, mk(0, 1, 2'd2, 0, 32'h0, w0, 32'h0, 0), "b2b st0");
    apply_op(1, mk(0, 1, 2'd2, 0, 32'h4, w1, 32'h0, 0), "b2b st1");
    drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c <= 7; c++) begin
      @(negedge CLK);
      exp_d = (c < 3) ? last_data[1] : (c < 6) ? w0 : w1;
      chk($sformatf("b2b c%0d valid", c), {31'b0, vld[1]}, (c == 3 || c == 6) ? 32'd1 : 32'd0);
      chk($sformatf("b2b c%0d stall", c), {31'b0, stall[1]}, (c <= 5) ? 32'd1 : 32'd0);
      chk($sformatf("b2b c%0d data", c), dout[1], exp_d);
      @(posedge CLK); #1;
      if (c == 2) drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
      else if (c == 0 || c == 1 || c == 3 || c == 4) scramble(1);
      else idle(1);
    end
    last_data[1] = w1;

    // Randomised traffic against the byte-level model
    for (int w = 0; w < 64; w++) begin
      v = mk(0, 1, 2'd2, 0, 32'(4 * w), $urandom, 32'h0, 0);
      apply_op(0, v, $sformatf("init%0d", w));
      mdl_store(v.addr, v.sz, v.wdata);
    end
    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 3));
      v.rd = op[0];
      v.wr = op[1];
      v.sz = 2'($urandom);
      v.uns = 1'($urandom);
      v.addr = $urandom & 32'hFFFF_F0FF;
      v.wdata = $urandom;
      n = nbytes(v.sz);
      if ($urandom_range(0, 3) != 0) v.addr = v.addr - (v.addr % n);
      v.err = (v.rd || v.wr) && ((v.addr % n) != 0);
      v.exp = (v.rd && !v.wr && !v.err) ? mdl_load(v.addr, v.sz, v.uns) : 32'h0;
      apply_op(0, v, $sformatf("rnd%0d", i));
      if (v.wr && !v.err) mdl_store(v.addr, v.sz, v.wdata);
    end

    // Reset in the middle of a load
    apply_op(0, mk(0, 1, 2'd2, 0, 32'h80, 32'h12345678, 32'h0, 0), "rst st");
    apply_op(0, mk(1, 0, 2'd2, 0, 32'h80, 32'h0, 32'h12345678, 0), "rst pre ld");
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    @(negedge CLK);
    chk("rst accept stall", {31'b0, stall[0]}, 32'd1);
    @(posedge CLK); #1;
    idle(0);
    #2 RESET = 1'b0;
    #1;
    chk("rst mid data", dout[0], 32'h0);
    chk("rst mid valid", {31'b0, vld[0]}, 32'd0);
    chk("rst mid stall", {31'b0, stall[0]}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int d = 0; d < ND; d++) last_data[d] = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      chk($sformatf("rst aborted c%0d valid", c), {31'b0, vld[0]}, 32'd0);
      chk($sformatf("rst aborted c%0d data", c), dout[0], 32'h0);
    end
    @(posedge CLK); #1;
    apply_op(0, mk(1, 0, 2'd2, 0, 32'h80, 32'h0, 32'h12345678, 0), "rst post ld");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
